// File: rtl/alarm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alarm_seq_ctrl                                                  |
// | Purpose  : Alarm-clock sequencer. Keeps a 24h time-of-day and an alarm     |
// |            setting, lets the user edit both through a five-state mode      |
// |            cycle, and rings / snoozes the alarm on minute ticks.           |
// | Ports    : clk, rst (sync, active-low)                                     |
// |            tick_i       - one pulse per displayed minute                   |
// |            btn_mode_i   - advance edit mode / cancel ringing               |
// |            btn_inc_i    - increment edited field, or toggle enable in RUN  |
// |            btn_snooze_i - snooze while ringing                             |
// |            disp3_o..disp0_o - BCD H1 H0 M1 M0 of time or alarm             |
// |            blink_hr_o, blink_min_o - field being edited                    |
// |            mode_o       - RUN=0 SET_HR=1 SET_MIN=2 AL_HR=3 AL_MIN=4         |
// |            alarm_en_o   - alarm armed                                      |
// |            led_o        - alarm ringing                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alarm_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_snooze_i,
  output logic [3:0] disp3_o,
  output logic [3:0] disp2_o,
  output logic [3:0] disp1_o,
  output logic [3:0] disp0_o,
  output logic       blink_hr_o,
  output logic       blink_min_o,
  output logic [2:0] mode_o,
  output logic       alarm_en_o,
  output logic       led_o
);

  localparam logic [2:0] c_ST_RUN     = 3'd0;
  localparam logic [2:0] c_ST_SET_HR  = 3'd1;
  localparam logic [2:0] c_ST_SET_MIN = 3'd2;
  localparam logic [2:0] c_ST_AL_HR   = 3'd3;
  localparam logic [2:0] c_ST_AL_MIN  = 3'd4;

  localparam logic [3:0] c_RING_LAST   = 4'd9;  // 10th tick of a ring ends it
  localparam logic [2:0] c_SNOOZE_LOAD = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [4:0]  tm_hr_q, tm_hr_d, al_hr_q, al_hr_d;
  logic [5:0]  tm_min_q, tm_min_d, al_min_q, al_min_d;
  logic        en_q, en_d, led_q, led_d;
  logic [3:0]  ring_q, ring_d;
  logic [2:0]  snz_q, snz_d;
  logic [15:0] disp_q, disp_d;
  logic        blink_hr_q, blink_hr_d, blink_min_q, blink_min_d;

  logic w_cancel, w_inc, w_adv, w_disarm, w_trig;

  function automatic logic [4:0] next_hr(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] next_min(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  // Binary (0..59) to two BCD digits by repeated subtraction of ten.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int k = 0; k < 5; k++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // btn_mode while ringing or snoozed only cancels; it does not step the mode.
  assign w_cancel = btn_mode_i & (led_q | (snz_q != 3'd0));
  // btn_mode takes priority over btn_inc in the same cycle.
  assign w_inc    = btn_inc_i & ~btn_mode_i;
  // Time runs everywhere except while it is being edited.
  assign w_adv    = tick_i & ((state_q == c_ST_RUN) | (state_q == c_ST_AL_HR) |
                              (state_q == c_ST_AL_MIN));
  assign w_disarm = w_inc & (state_q == c_ST_RUN) & en_q;

  // State register plus datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= c_ST_RUN;
      tm_hr_q     <= 5'd0;
      tm_min_q    <= 6'd0;
      al_hr_q     <= 5'd7;
      al_min_q    <= 6'd0;
      en_q        <= 1'b0;
      led_q       <= 1'b0;
      ring_q      <= 4'd0;
      snz_q       <= 3'd0;
      disp_q      <= 16'h0000;
      blink_hr_q  <= 1'b0;
      blink_min_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tm_hr_q     <= tm_hr_d;
      tm_min_q    <= tm_min_d;
      al_hr_q     <= al_hr_d;
      al_min_q    <= al_min_d;
      en_q        <= en_d;
      led_q       <= led_d;
      ring_q      <= ring_d;
      snz_q       <= snz_d;
      disp_q      <= disp_d;
      blink_hr_q  <= blink_hr_d;
      blink_min_q <= blink_min_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_RUN:     if (btn_mode_i && !w_cancel) state_d = c_ST_SET_HR;
      c_ST_SET_HR:  if (btn_mode_i && !w_cancel) state_d = c_ST_SET_MIN;
      c_ST_SET_MIN: if (btn_mode_i && !w_cancel) state_d = c_ST_AL_HR;
      c_ST_AL_HR:   if (btn_mode_i && !w_cancel) state_d = c_ST_AL_MIN;
      c_ST_AL_MIN:  if (btn_mode_i && !w_cancel) state_d = c_ST_RUN;
      default:      state_d = c_ST_RUN;
    endcase
  end

  // Time, alarm, ring and snooze datapath
  always_comb begin
    tm_hr_d  = tm_hr_q;
    tm_min_d = tm_min_q;
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    en_d     = en_q;
    led_d    = led_q;
    ring_d   = ring_q;
    snz_d    = snz_q;
    w_trig   = 1'b0;

    if (w_adv) begin
      tm_min_d = next_min(tm_min_q);
      if (tm_min_q == 6'd59) tm_hr_d = next_hr(tm_hr_q);
    end

    // Field edits never carry into the neighbouring field.
    if (w_inc) begin
      case (state_q)
        c_ST_RUN:     en_d     = ~en_q;
        c_ST_SET_HR:  tm_hr_d  = next_hr(tm_hr_q);
        c_ST_SET_MIN: tm_min_d = next_min(tm_min_q);
        c_ST_AL_HR:   al_hr_d  = next_hr(al_hr_q);
        c_ST_AL_MIN:  al_min_d = next_min(al_min_q);
        default:      ;
      endcase
    end

    if (led_q && tick_i) begin
      if (ring_q == c_RING_LAST) begin
        led_d  = 1'b0;
        ring_d = 4'd0;
      end else begin
        ring_d = ring_q + 4'd1;
      end
    end

    if ((snz_q != 3'd0) && tick_i) begin
      snz_d = snz_q - 3'd1;
      if (snz_q == 3'd1) begin
        led_d  = 1'b1;
        ring_d = 4'd0;
      end
    end

    if (btn_snooze_i && led_q) begin
      led_d  = 1'b0;
      ring_d = 4'd0;
      snz_d  = c_SNOOZE_LOAD;
    end

    // Only a tick can arm the ring; manual edits that land on the alarm cannot.
    w_trig = w_adv & en_d & (tm_hr_d == al_hr_d) & (tm_min_d == al_min_d);
    if (w_trig) begin
      led_d  = 1'b1;
      ring_d = 4'd0;
      snz_d  = 3'd0;
    end

    if (w_cancel || w_disarm) begin
      led_d  = 1'b0;
      ring_d = 4'd0;
      snz_d  = 3'd0;
    end
  end

  // Output decode from next-state values so registered outputs track the state
  always_comb begin
    blink_hr_d  = (state_d == c_ST_SET_HR)  || (state_d == c_ST_AL_HR);
    blink_min_d = (state_d == c_ST_SET_MIN) || (state_d == c_ST_AL_MIN);
    if ((state_d == c_ST_AL_HR) || (state_d == c_ST_AL_MIN))
      disp_d = {to_bcd({1'b0, al_hr_d}), to_bcd(al_min_d)};
    else
      disp_d = {to_bcd({1'b0, tm_hr_d}), to_bcd(tm_min_d)};
  end

  assign disp3_o     = disp_q[15:12];
  assign disp2_o     = disp_q[11:8];
  assign disp1_o     = disp_q[7:4];
  assign disp0_o     = disp_q[3:0];
  assign blink_hr_o  = blink_hr_q;
  assign blink_min_o = blink_min_q;
  assign mode_o      = state_q;
  assign alarm_en_o  = en_q;
  assign led_o       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alarm_seq_ctrl                                               |
// | Purpose  : Self-checking bench for alarm_seq_ctrl: vector table, directed  |
// |            multi-cycle sequences and random stimulus against a model that  |
// |            tracks time and alarm as minutes-of-day.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alarm_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, bm = 1'b0, bi = 1'b0, bs = 1'b0;
  logic [3:0] d3, d2, d1, d0;
  logic bh, bmn, en, led;
  logic [2:0] mode;
  logic [15:0] disp_all;

  int checks = 0;
  int errors = 0;

  // Reference state: time/alarm as minutes since midnight
  int m_mode = 0, m_time = 0, m_alarm = 420, m_ring = 0, m_snz = 0;
  logic m_en = 1'b0, m_led = 1'b0;

  typedef struct {
    logic [4:0]  in;      // {rst, tick, mode, inc, snooze}
    logic [2:0]  e_mode;
    logic [15:0] e_disp;
    logic [3:0]  e_flg;   // {blink_hr, blink_min, alarm_en, led}
  } vec_t;
  vec_t tbl[17];

  always #5 clk = ~clk;

  alarm_seq_ctrl dut (
    .clk(clk), .rst(rst), .tick_i(tick), .btn_mode_i(bm), .btn_inc_i(bi),
    .btn_snooze_i(bs), .disp3_o(d3), .disp2_o(d2), .disp1_o(d1), .disp0_o(d0),
    .blink_hr_o(bh), .blink_min_o(bmn), .mode_o(mode), .alarm_en_o(en),
    .led_o(led)
  );

  assign disp_all = {d3, d2, d1, d0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] pack_act();
    return {mode, disp_all, bh, bmn, en, led};
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    int hh, mm;
    hh = v / 60;
    mm = v % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic model_step(input logic r, t, b_m, b_i, b_s);
    int nt, na;
    logic cancel, inc, runs, trig, o_en, o_led;
    int o_snz;
    if (!r) begin
      m_mode = 0; m_time = 0; m_alarm = 7 * 60; m_en = 1'b0;
      m_led = 1'b0; m_ring = 0; m_snz = 0;
      return;
    end
    o_en = m_en; o_led = m_led; o_snz = m_snz;
    cancel = b_m && (o_led || o_snz > 0);
    inc    = b_i && !b_m;
    runs   = (m_mode == 0) || (m_mode == 3) || (m_mode == 4);
    nt = m_time;
    na = m_alarm;
    if (t && runs) nt = (m_time + 1) % 1440;
    if (inc) begin
      case (m_mode)
        0: m_en = !o_en;
        1: nt = ((m_time / 60 + 1) % 24) * 60 + m_time % 60;
        2: nt = (m_time / 60) * 60 + (m_time % 60 + 1) % 60;
        3: na = ((m_alarm / 60 + 1) % 24) * 60 + m_alarm % 60;
        4: na = (m_alarm / 60) * 60 + (m_alarm % 60 + 1) % 60;
        default: ;
      endcase
    end
    if (o_led && t) begin
      m_ring++;
      if (m_ring == 10) begin m_led = 1'b0; m_ring = 0; end
    end
    if (o_snz > 0 && t) begin
      m_snz = o_snz - 1;
      if (m_snz == 0) begin m_led = 1'b1; m_ring = 0; end
    end
    if (b_s && o_led) begin m_led = 1'b0; m_ring = 0; m_snz = 5; end
    trig = t && runs && m_en && (nt == na);
    if (trig) begin m_led = 1'b1; m_ring = 0; m_snz = 0; end
    if (cancel || (inc && m_mode == 0 && o_en)) begin
      m_led = 1'b0; m_ring = 0; m_snz = 0;
    end
    m_time  = nt;
    m_alarm = na;
    if (b_m && !cancel) m_mode = (m_mode + 1) % 5;
  endtask

  task automatic model_check();
    logic [22:0] exp;
    int shown;
    shown = (m_mode == 3 || m_mode == 4) ? m_alarm : m_time;
    exp = {3'(m_mode), bcd_of(shown), (m_mode == 1 || m_mode == 3),
           (m_mode == 2 || m_mode == 4), m_en, m_led};
    chk("model", 32'(pack_act()), 32'(exp));
  endtask

  // One clock: drive inputs, step the model at the edge, compare after it
  task automatic cyc(input logic r, t, b_m, b_i, b_s);
    rst = r; tick = t; bm = b_m; bi = b_i; bs = b_s;
    @(posedge clk);
    model_step(r, t, b_m, b_i, b_s);
    #1;
    model_check();
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Reset, then program time/alarm through the edit modes and return to RUN
  task automatic setup(input int th, tm, ah, am, input logic arm);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    press_mode(); press_inc(th);
    press_mode(); press_inc(tm);
    press_mode(); press_inc((ah + 24 - 7) % 24);
    press_mode(); press_inc(am);
    press_mode();
    if (arm) press_inc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{5'b00000, 3'd0, 16'h0000, 4'b0000};  // reset
    tbl[1]  = '{5'b10110, 3'd1, 16'h0000, 4'b1000};  // mode+inc: inc ignored
    tbl[2]  = '{5'b10010, 3'd1, 16'h0100, 4'b1000};
    tbl[3]  = '{5'b11010, 3'd1, 16'h0200, 4'b1000};  // tick ignored in SET_HR
    tbl[4]  = '{5'b10010, 3'd1, 16'h0300, 4'b1000};
    tbl[5]  = '{5'b11000, 3'd1, 16'h0300, 4'b1000};
    tbl[6]  = '{5'b10100, 3'd2, 16'h0300, 4'b0100};
    tbl[7]  = '{5'b10010, 3'd2, 16'h0301, 4'b0100};
    tbl[8]  = '{5'b10100, 3'd3, 16'h0700, 4'b1000};  // alarm shown
    tbl[9]  = '{5'b10010, 3'd3, 16'h0800, 4'b1000};
    tbl[10] = '{5'b10100, 3'd4, 16'h0800, 4'b0100};
    tbl[11] = '{5'b11010, 3'd4, 16'h0801, 4'b0100};  // tick+inc in AL_MIN
    tbl[12] = '{5'b10100, 3'd0, 16'h0302, 4'b0000};  // time advanced too
    tbl[13] = '{5'b10010, 3'd0, 16'h0302, 4'b0010};  // arm
    tbl[14] = '{5'b11000, 3'd0, 16'h0303, 4'b0010};
    tbl[15] = '{5'b01111, 3'd0, 16'h0000, 4'b0000};  // reset with busy inputs
    tbl[16] = '{5'b11000, 3'd0, 16'h0001, 4'b0000};

    for (int k = 0; k < 17; k++) begin
      cyc(tbl[k].in[4], tbl[k].in[3], tbl[k].in[2], tbl[k].in[1], tbl[k].in[0]);
      chk($sformatf("vec%0d", k), 32'(pack_act()),
          32'({tbl[k].e_mode, tbl[k].e_disp, tbl[k].e_flg}));
    end

    // Rollover 23:59 -> 00:00
    setup(23, 59, 7, 0, 1'b0);
    chk("preset_2359", 32'(disp_all), 32'h2359);
    ticks(1);
    chk("rollover", 32'(disp_all), 32'h0000);

    // Trigger and ten-tick ring
    setup(6, 59, 7, 0, 1'b1);
    chk("armed", 32'(en), 32'd1);
    ticks(1);
    chk("trigger", 32'({led, disp_all}), 32'({1'b1, 16'h0700}));
    ticks(9);
    chk("ring_9", 32'(led), 32'd1);
    ticks(1);
    chk("ring_end", 32'(led), 32'd0);

    // Snooze, re-ring, then cancel by btn_mode
    setup(6, 59, 7, 0, 1'b1);
    ticks(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("snooze_off", 32'(led), 32'd0);
    ticks(4);
    chk("snooze_4", 32'(led), 32'd0);
    ticks(1);
    chk("snooze_rering", 32'(led), 32'd1);
    press_mode();
    chk("mode_cancel", 32'({mode, led}), 32'd0);
    ticks(6);
    chk("cancel_sticks", 32'(led), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(6);
    chk("snooze_idle", 32'(led), 32'd0);

    // Disarming in RUN stops the ring
    setup(6, 59, 7, 0, 1'b1);
    ticks(1);
    press_inc(1);
    chk("disarm_cancel", 32'({en, led}), 32'd0);

    // Reset mid-ring in AL_HR
    setup(6, 59, 7, 0, 1'b1);
    press_mode(); press_mode(); press_mode();
    ticks(1);
    chk("ring_in_alhr", 32'({mode, led, disp_all}), 32'({3'd3, 1'b1, 16'h0700}));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_midring", 32'(pack_act()), 32'd0);
    ticks(1);
    chk("resume", 32'(disp_all), 32'h0001);

    // Random stimulus near the alarm time
    setup(6, 30, 7, 0, 1'b1);
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 1999) != 0),
          ($urandom_range(0, 99) < 60),
          ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
